// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared selector codes, FSM encodings and default widths
package pipe_pkg;

  localparam int DEF_REG_ADDR_W = 5;

  // Operand-source selector codes for the EX-stage 3:1 muxes
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Pipeline control FSM states
  localparam logic RUN      = 1'b0;
  localparam logic MEM_HOLD = 1'b1;

endpackage

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - priority forwarding compare for one EX operand
module fwd_select
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_valid,
  input  logic                  mem_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_valid,
  input  logic                  wb_regwrite,
  output logic [1:0]            sel
);

  // MEM is the younger producer so it wins over WB; r0 is never forwarded
  always_comb begin
    sel = FWD_REG;
    if (ex_valid) begin
      if (mem_valid && mem_regwrite && (mem_rd != '0) && (mem_rd == src)) begin
        sel = FWD_MEM;
      end else if (wb_valid && wb_regwrite && (wb_rd != '0) && (wb_rd == src)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// rtl/forward_hazard_unit.sv - forwarding selectors and stall/bubble control; FWD_STALL_COUNT_EN adds a stall counter
module forward_hazard_unit
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  mem_wait,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  stall,
  output logic                  bubble,
  output logic [CNT_W-1:0]      stall_count
);

  logic                  state;
  logic                  ex_valid, ex_regwrite, ex_memread;
  logic [REG_ADDR_W-1:0] ex_rs, ex_rt, ex_rd;
  logic                  mem_valid, mem_regwrite;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  wb_valid, wb_regwrite;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic                  load_use;
  logic [1:0]            sel_a, sel_b;

  // Load in EX whose result an issuing ID instruction needs
  always_comb begin
    load_use = ex_valid && ex_memread && ex_regwrite && (ex_rd != '0) &&
               id_valid && ((id_rs == ex_rd) || (id_rt == ex_rd));
  end

  // mem_wait freezes everything and outranks the load-use bubble; reset masks both
  always_comb begin
    stall  = !reset && (mem_wait || load_use);
    bubble = !reset && !mem_wait && load_use;
    fwd_a  = reset ? FWD_REG : sel_a;
    fwd_b  = reset ? FWD_REG : sel_b;
  end

  // Track whether the pipeline is being held for data memory
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:      if (mem_wait)  state <= MEM_HOLD;
        MEM_HOLD: if (!mem_wait) state <= RUN;
        default:  state <= RUN;
      endcase
    end
  end

  // Shadow EX/MEM/WB tags; frozen while memory waits, EX gets a bubble on load-use
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid  <= 1'b0;
      mem_valid <= 1'b0;
      wb_valid  <= 1'b0;
    end else if (!mem_wait) begin
      wb_valid     <= mem_valid;
      wb_rd        <= mem_rd;
      wb_regwrite  <= mem_regwrite;
      mem_valid    <= ex_valid;
      mem_rd       <= ex_rd;
      mem_regwrite <= ex_regwrite;
      if (load_use) begin
        ex_valid <= 1'b0;
      end else begin
        ex_valid    <= id_valid;
        ex_rs       <= id_rs;
        ex_rt       <= id_rt;
        ex_rd       <= id_rd;
        ex_regwrite <= id_regwrite;
        ex_memread  <= id_memread;
      end
    end
  end

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .src          (ex_rs),
    .ex_valid     (ex_valid),
    .mem_rd       (mem_rd),
    .mem_valid    (mem_valid),
    .mem_regwrite (mem_regwrite),
    .wb_rd        (wb_rd),
    .wb_valid     (wb_valid),
    .wb_regwrite  (wb_regwrite),
    .sel          (sel_a)
  );

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .src          (ex_rt),
    .ex_valid     (ex_valid),
    .mem_rd       (mem_rd),
    .mem_valid    (mem_valid),
    .mem_regwrite (mem_regwrite),
    .wb_rd        (wb_rd),
    .wb_valid     (wb_valid),
    .wb_regwrite  (wb_regwrite),
    .sel          (sel_b)
  );

`ifdef FWD_STALL_COUNT_EN
  // Saturating count of every stalled cycle, whatever the cause
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_forward_hazard_unit.sv
// tb/tb_forward_hazard_unit.sv - directed and random checks of forward_hazard_unit against a pipeline model
module tb_forward_hazard_unit;

  localparam int AW = 5;
  localparam int CW = 16;

  logic          clk;
  logic          reset;
  logic          id_valid;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic          id_regwrite, id_memread;
  logic          mem_wait;
  logic [1:0]    fwd_a, fwd_b;
  logic          stall, bubble;
  logic [CW-1:0] stall_count;

  int n_checks = 0;
  int n_pass   = 0;

  forward_hazard_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .mem_wait    (mem_wait),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall       (stall),
    .bubble      (bubble),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: pipe[0] is the instruction in EX, pipe[d] is d stages further along
  typedef struct {
    bit          v;
    bit [AW-1:0] rs, rt, rd;
    bit          rw, mr;
  } instr_t;

  instr_t pipe[3];
  int     m_cnt;

  function automatic bit m_hazard();
    return !reset && id_valid && pipe[0].v && pipe[0].mr && pipe[0].rw && pipe[0].rd != 0 &&
           (pipe[0].rd == id_rs || pipe[0].rd == id_rt);
  endfunction

  function automatic logic [1:0] m_fwd(bit [AW-1:0] src);
    if (reset || !pipe[0].v) return 2'd0;
    for (int d = 1; d <= 2; d++)
      if (pipe[d].v && pipe[d].rw && pipe[d].rd != 0 && pipe[d].rd == src)
        return (d == 1) ? 2'd1 : 2'd2;
    return 2'd0;
  endfunction

  function automatic logic m_stall();
    return !reset && (mem_wait || m_hazard());
  endfunction

  function automatic logic m_bubble();
    return !reset && !mem_wait && m_hazard();
  endfunction

  function automatic logic [CW-1:0] m_count();
`ifdef FWD_STALL_COUNT_EN
    return m_cnt[CW-1:0];
`else
    return '0;
`endif
  endfunction

  task automatic tick();
    bit     hz;
    instr_t nxt;
    @(posedge clk);
    hz = m_hazard();
    if (reset) begin
      foreach (pipe[i]) pipe[i].v = 0;
      m_cnt = 0;
    end else begin
      if ((mem_wait || hz) && m_cnt < (1 << CW) - 1) m_cnt++;
      if (!mem_wait) begin
        nxt = '{v: id_valid && !hz, rs: id_rs, rt: id_rt, rd: id_rd, rw: id_regwrite, mr: id_memread};
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = nxt;
      end
    end
    #1;
  endtask

  task automatic drive(bit v, int rs, int rt, int rd, bit rw, bit mr);
    id_valid    = v;
    id_rs       = AW'(rs);
    id_rt       = AW'(rt);
    id_rd       = AW'(rd);
    id_regwrite = rw;
    id_memread  = mr;
  endtask

  task automatic flush();
    drive(0, 0, 0, 0, 0, 0);
    mem_wait = 0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset = 1;
    mem_wait = 1;
    drive(1, 1, 2, 3, 1, 1);
    tick();
    tick();
    reset = 0;
    mem_wait = 0;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++; if (fwd_a !== 2'b00) $display("FAIL reset_fwd_a: got %0d want 0", fwd_a); else n_pass++;
    n_checks++; if (fwd_b !== 2'b00) $display("FAIL reset_fwd_b: got %0d want 0", fwd_b); else n_pass++;
    n_checks++; if (stall !== 1'b0) $display("FAIL reset_stall: got %0d want 0", stall); else n_pass++;
    n_checks++; if (bubble !== 1'b0) $display("FAIL reset_bubble: got %0d want 0", bubble); else n_pass++;
    n_checks++; if (stall_count !== '0) $display("FAIL reset_count: got %0d want 0", stall_count); else n_pass++;
  endtask

  task automatic test_mem_forward();
    flush();
    drive(1, 1, 2, 3, 1, 0); tick();
    drive(1, 3, 4, 5, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++; if (fwd_a !== 2'b01) $display("FAIL memfwd_a: got %0d want 1", fwd_a); else n_pass++;
    n_checks++; if (fwd_b !== 2'b00) $display("FAIL memfwd_b: got %0d want 0", fwd_b); else n_pass++;
    n_checks++; if (stall !== 1'b0) $display("FAIL memfwd_stall: got %0d want 0", stall); else n_pass++;
  endtask

  task automatic test_wb_priority();
    flush();
    drive(1, 1, 2, 3, 1, 0); tick();
    drive(1, 1, 2, 3, 1, 0); tick();
    drive(1, 3, 0, 4, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++; if (fwd_a !== 2'b01) $display("FAIL prio_mem_wins: got %0d want 1", fwd_a); else n_pass++;
    flush();
    drive(1, 1, 2, 3, 1, 0); tick();
    drive(1, 1, 2, 6, 1, 0); tick();
    drive(1, 3, 0, 4, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++; if (fwd_a !== 2'b10) $display("FAIL prio_wb: got %0d want 2", fwd_a); else n_pass++;
  endtask

  task automatic test_load_use();
    flush();
    drive(1, 1, 0, 7, 1, 1); tick();
    drive(1, 7, 7, 8, 1, 0);
    @(negedge clk);
    n_checks++; if (stall !== 1'b1) $display("FAIL lu_stall: got %0d want 1", stall); else n_pass++;
    n_checks++; if (bubble !== 1'b1) $display("FAIL lu_bubble: got %0d want 1", bubble); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (stall !== 1'b0) $display("FAIL lu_one_cycle: got %0d want 0", stall); else n_pass++;
    tick();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++; if (fwd_a !== 2'b10) $display("FAIL lu_fwd_a: got %0d want 2", fwd_a); else n_pass++;
    n_checks++; if (fwd_b !== 2'b10) $display("FAIL lu_fwd_b: got %0d want 2", fwd_b); else n_pass++;
  endtask

  task automatic test_reg_zero();
    flush();
    drive(1, 1, 2, 0, 1, 0); tick();
    drive(1, 0, 0, 4, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++; if (fwd_a !== 2'b00) $display("FAIL r0_fwd: got %0d want 0", fwd_a); else n_pass++;
    flush();
    drive(1, 1, 0, 0, 1, 1); tick();
    drive(1, 0, 0, 5, 1, 0);
    @(negedge clk);
    n_checks++; if (stall !== 1'b0) $display("FAIL r0_no_stall: got %0d want 0", stall); else n_pass++;
    tick();
  endtask

  task automatic test_mem_wait();
    flush();
    drive(1, 1, 2, 9, 1, 0); tick();
    drive(1, 9, 1, 10, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    mem_wait = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++; if (stall !== 1'b1) $display("FAIL mw_stall[%0d]: got %0d want 1", c, stall); else n_pass++;
      n_checks++; if (bubble !== 1'b0) $display("FAIL mw_bubble[%0d]: got %0d want 0", c, bubble); else n_pass++;
      n_checks++; if (fwd_a !== 2'b01) $display("FAIL mw_fwd_a[%0d]: got %0d want 1", c, fwd_a); else n_pass++;
      tick();
    end
    mem_wait = 0;
    @(negedge clk);
    n_checks++; if (stall !== 1'b0) $display("FAIL mw_release: got %0d want 0", stall); else n_pass++;
    n_checks++; if (fwd_a !== 2'b01) $display("FAIL mw_held_fwd: got %0d want 1", fwd_a); else n_pass++;
    n_checks++; if (stall_count !== m_count()) $display("FAIL mw_count: got %0d want %0d", stall_count, m_count()); else n_pass++;
    tick();
  endtask

  task automatic test_random();
    flush();
    for (int c = 0; c < 400; c++) begin
      reset    = ($urandom_range(0, 49) == 0);
      mem_wait = ($urandom_range(0, 5) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      @(negedge clk);
      n_checks++; if (fwd_a !== m_fwd(pipe[0].rs)) $display("FAIL rnd_fwd_a[%0d]: got %0d want %0d", c, fwd_a, m_fwd(pipe[0].rs)); else n_pass++;
      n_checks++; if (fwd_b !== m_fwd(pipe[0].rt)) $display("FAIL rnd_fwd_b[%0d]: got %0d want %0d", c, fwd_b, m_fwd(pipe[0].rt)); else n_pass++;
      n_checks++; if (stall !== m_stall()) $display("FAIL rnd_stall[%0d]: got %0d want %0d", c, stall, m_stall()); else n_pass++;
      n_checks++; if (bubble !== m_bubble()) $display("FAIL rnd_bubble[%0d]: got %0d want %0d", c, bubble, m_bubble()); else n_pass++;
      n_checks++; if (stall_count !== m_count()) $display("FAIL rnd_count[%0d]: got %0d want %0d", c, stall_count, m_count()); else n_pass++;
      tick();
    end
    reset = 0;
  endtask

  task automatic test_reset_in_hold();
    flush();
    drive(1, 1, 0, 7, 1, 1); tick();
    drive(1, 7, 2, 8, 1, 0);
    mem_wait = 1;
    @(negedge clk);
    n_checks++; if (stall !== 1'b1 || bubble !== 1'b0) $display("FAIL rh_pre: got stall=%0d bubble=%0d want 1/0", stall, bubble); else n_pass++;
    tick();
    reset = 1;
    tick();
    reset = 0;
    mem_wait = 0;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) $display("FAIL rh_fwd: got %0d/%0d want 0/0", fwd_a, fwd_b); else n_pass++;
    n_checks++; if (stall !== 1'b0 || bubble !== 1'b0) $display("FAIL rh_ctrl: got %0d/%0d want 0/0", stall, bubble); else n_pass++;
    n_checks++; if (stall_count !== '0) $display("FAIL rh_count: got %0d want 0", stall_count); else n_pass++;
    drive(1, 7, 8, 3, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) $display("FAIL rh_no_fwd: got %0d/%0d want 0/0", fwd_a, fwd_b); else n_pass++;
  endtask

  initial begin
    foreach (pipe[i]) pipe[i] = '{v: 0, rs: 0, rt: 0, rd: 0, rw: 0, mr: 0};
    m_cnt = 0;
    reset = 1;
    mem_wait = 0;
    drive(0, 0, 0, 0, 0, 0);
    test_reset();
    test_mem_forward();
    test_wb_priority();
    test_load_use();
    test_reg_zero();
    test_mem_wait();
    test_random();
    test_reset_in_hold();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
